// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute units: opcodes, widths and FSM state.
package alu_pkg;

    localparam int unsigned ALU_XLEN = 32;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned CNT_W    = 6;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_SLT  = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b01001;
    localparam logic [4:0] ALU_MUL  = 5'b01010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; shared with the single-cycle core.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = ALU_XLEN
) (
    input  logic [4:0]      aluopcode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            recognised
);

    always_comb begin
        result     = '0;
        recognised = 1'b1;
        unique case (aluopcode)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            // Shifts and MUL are sequenced by the caller; only flag them as known.
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL: result = '0;
            default:  recognised = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute stage: one-bit-per-cycle shifts, 32-step shift-add MUL,
// single-cycle ops via alu_comb, valid/ready handshake on both sides.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluopcode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_e            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   shreg_q, shreg_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;

    logic [XLEN-1:0]   comb_result;
    logic              comb_recognised;
    logic [XLEN-1:0]   shift_nxt;
    logic [XLEN-1:0]   acc_nxt;
    logic [SHAMT_W-1:0] shamt;
    logic              done_now;
    logic [XLEN-1:0]   done_val;
    logic              done_ill;

    alu_comb #(.XLEN(XLEN)) u_comb (
        .aluopcode  (aluopcode),
        .a          (op_a),
        .b          (op_b),
        .result     (comb_result),
        .recognised (comb_recognised)
    );

    assign shamt    = op_b[SHAMT_W-1:0];
    assign in_ready = (state_q == ST_IDLE);

    always_comb begin
        unique case (op_q)
            ALU_SLL: shift_nxt = {shreg_q[XLEN-2:0], 1'b0};
            ALU_SRA: shift_nxt = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shift_nxt = {1'b0, shreg_q[XLEN-1:1]};
        endcase
        acc_nxt = mplr_q[0] ? (acc_q + shreg_q) : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(aluopcode))
                        state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                    else if (aluopcode == ALU_MUL)
                        state_d = ST_MUL;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_MUL:   if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        shreg_d     = shreg_q;
        mplr_d      = mplr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        done_now    = 1'b0;
        done_val    = '0;
        done_ill    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = aluopcode;
                    shreg_d = op_a;
                    mplr_d  = op_b;
                    acc_d   = '0;
                    cnt_d   = (aluopcode == ALU_MUL) ? CNT_W'(XLEN) : CNT_W'(shamt);
                    if (is_shift(aluopcode)) begin
                        if (shamt == '0) begin
                            done_now = 1'b1;
                            done_val = op_a;
                        end
                    end else if (aluopcode != ALU_MUL) begin
                        done_now = 1'b1;
                        done_val = comb_result;
                        done_ill = ~comb_recognised;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = shift_nxt;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_now = 1'b1;
                    done_val = shift_nxt;
                end
            end
            ST_MUL: begin
                acc_d   = acc_nxt;
                shreg_d = {shreg_q[XLEN-2:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[XLEN-1:1]};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_now = 1'b1;
                    done_val = acc_nxt;
                end
            end
            ST_DONE: if (out_ready) out_valid_d = 1'b0;
            default: out_valid_d = 1'b0;
        endcase
        if (done_now) begin
            result_d    = done_val;
            zero_d      = (done_val == '0);
            illegal_d   = done_ill;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            shreg_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            shreg_q     <= shreg_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed test-plan vectors plus
// randomized ops against a plain-arithmetic reference model.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  aluopcode = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluopcode (aluopcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b % 32);
        ill = 1'b0;
        lat = 1;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  begin r = a << sh; lat = sh + 1; end
            5'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  begin r = a >> sh; lat = sh + 1; end
            5'd7:  begin r = $signed(a) >>> sh; lat = sh + 1; end
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: begin r = a * b; lat = 33; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // Issue one op from IDLE, measure latency, then complete the handshake after 'stall' cycles.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int stall,
                         output logic [31:0] r, output logic z, output logic il, output int lat,
                         output logic rdy_ok);
        aluopcode = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        aluopcode = 5'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 1; rdy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_ok = 1'b0;
        r = result; z = zero; il = illegal;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0b want 1", zero); end
        n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0b want 0", illegal); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t dv [9] = '{
        '{5'b00000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1},
        '{5'b00001, 32'd5,        32'd5,        32'd0,        1'b0, 1},
        '{5'b00111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5},
        '{5'b00010, 32'd1,        32'd0,        32'd1,        1'b0, 1},
        '{5'b01010, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 33},
        '{5'b01010, 32'd12345,    32'd678,      32'd8369910,  1'b0, 33},
        '{5'b00011, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1},
        '{5'b00100, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1},
        '{5'b11111, 32'h12345678, 32'h9ABCDEF0, 32'd0,        1'b1, 1}
    };

    task automatic test_directed();
        logic [31:0] r; logic z, il, rok; int lat;
        for (int i = 0; i < 9; i++) begin
            do_op(dv[i].op, dv[i].a, dv[i].b, 0, r, z, il, lat, rok);
            n_cmp++; if (r !== dv[i].r) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, r, dv[i].r); end
            n_cmp++; if (z !== (dv[i].r == 32'd0)) begin n_fail++; $display("FAIL dir%0d_zero got %0b want %0b", i, z, dv[i].r == 32'd0); end
            n_cmp++; if (il !== dv[i].ill) begin n_fail++; $display("FAIL dir%0d_illegal got %0b want %0b", i, il, dv[i].ill); end
            n_cmp++; if (lat != dv[i].lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, dv[i].lat); end
            n_cmp++; if (rok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready_busy got high want low", i); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, b; logic z, il, eil, rok; logic [4:0] op; int lat, elat;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            ref_model(op, a, b, er, eil, elat);
            do_op(op, a, b, $urandom_range(0, 3), r, z, il, lat, rok);
            n_cmp++; if (r !== er) begin n_fail++; $display("FAIL rnd%0d_result op=%0d got %h want %h", i, op, r, er); end
            n_cmp++; if (z !== (er == 32'd0)) begin n_fail++; $display("FAIL rnd%0d_zero got %0b want %0b", i, z, er == 32'd0); end
            n_cmp++; if (il !== eil) begin n_fail++; $display("FAIL rnd%0d_illegal got %0b want %0b", i, il, eil); end
            n_cmp++; if (lat != elat) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, lat, elat); end
            n_cmp++; if (rok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_in_ready_busy got high want low", i); end
        end
    endtask

    task automatic test_backpressure();
        int w;
        aluopcode = 5'b00101; op_a = 32'hF0F0; op_b = 32'h0FF0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin aluopcode = 5'b00000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; end
            else in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1 || result !== 32'hFF00 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d valid=%0b result=%h ready=%0b want 1/0000ff00/0", c, out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_ignored%0d valid=%0b ready=%0b want 0/1", c, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] er, a, b; logic eil; logic [4:0] op; int elat, acc, outs;
        logic acc_now;
        acc = 0; outs = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            op = 5'($urandom_range(0, 2)) * 5'd4 + 5'd1;  // SUB, XOR, AND
            a = $urandom; b = $urandom;
            aluopcode = op; op_a = a; op_b = b; in_valid = 1'b1;
            acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) begin ref_model(op, a, b, er, eil, elat); q.push_back(er); acc++; end
            if (out_valid) begin
                outs++;
                n_cmp++; if (q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected result %h", result); end
                else begin
                    er = q.pop_front();
                    if (result !== er) begin n_fail++; $display("FAIL b2b_result got %h want %h", result, er); end
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (acc != 4 || outs != 4) begin n_fail++; $display("FAIL b2b_rate accepts=%0d results=%0d want 4/4", acc, outs); end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; logic z, il, rok; int lat; logic seen;
        aluopcode = 5'b01010; op_a = 32'hDEADBEEF; op_b = 32'h1234567; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL rstmul_outputs valid=%0b result=%h zero=%0b ill=%0b want 0/0/1/0", out_valid, result, zero, illegal);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_in_ready got %0b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmul_discard got out_valid want none"); end
        do_op(5'b00000, 32'd2, 32'd3, 0, r, z, il, lat, rok);
        n_cmp++; if (r !== 32'd5) begin n_fail++; $display("FAIL rstmul_add got %h want 5", r); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL rstmul_add_latency got %0d want 1", lat); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
